// File: rtl/de_scoreboard_rf.sv
// de_scoreboard_rf
// Decode-stage register file plus hazard scoreboard. Every architectural
// register has a small pending-write counter: issue of a writer bumps it and
// writeback drops it. Any source whose counter is nonzero is a RAW hazard.
// A shadow FSM stalls issue for BR_SHADOW cycles after a control instruction
// fires, or less if the branch resolves earlier.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   issue_valid_in      decode slot holds an instruction
//   rs_in/rs_read_in    packed source register numbers / per-port read flags
//   rd_in/wr_reg_in     destination register / instruction writes rd_in
//   is_ctrl_in          instruction is a branch, JAL or JALR
//   wb_valid_in/wb_regno_in/wb_val_in  writeback port
//   ctrl_resolve_in     outstanding control instruction resolved
//   regval_out          packed read data, one DBITS slice per read port
//   stall_out           DE stall to FE
//   issue_fire_out      instruction leaves decode this cycle
//   busy_vec_out        per-register "write pending" flags (registered)
//   err_out             sticky pending-counter underflow flag

// One pending-write counter. Saturation is prevented upstream by the stall,
// the guard here only keeps the counter from wrapping if that ever breaks.
module de_sb_pend_cnt #(
  parameter int PEND_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_inc,
  input  logic                 i_dec,
  output logic [PEND_BITS-1:0] o_cnt,
  output logic                 o_uflow
);
  logic [PEND_BITS-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  r_cnt <= '0;
    else if (i_inc && !i_dec && r_cnt != '1)     r_cnt <= r_cnt + 1'b1;
    else if (i_dec && !i_inc && r_cnt != '0)     r_cnt <= r_cnt - 1'b1;
  end

  assign o_cnt   = r_cnt;
  // a simultaneous issue covers the writeback, so only a lone dec underflows
  assign o_uflow = i_dec && !i_inc && (r_cnt == '0);
endmodule

module de_scoreboard_rf #(
  parameter  int DBITS     = 32,
  parameter  int REGWORDS  = 32,
  parameter  int NREAD     = 2,
  parameter  int PEND_BITS = 2,
  parameter  int BR_SHADOW = 3,
  parameter  int BYPASS_WB = 1,
  localparam int REGNOBITS = $clog2(REGWORDS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue_valid_in,
  input  logic [NREAD*REGNOBITS-1:0] rs_in,
  input  logic [NREAD-1:0]           rs_read_in,
  input  logic [REGNOBITS-1:0]       rd_in,
  input  logic                       wr_reg_in,
  input  logic                       is_ctrl_in,
  input  logic                       wb_valid_in,
  input  logic [REGNOBITS-1:0]       wb_regno_in,
  input  logic [DBITS-1:0]           wb_val_in,
  input  logic                       ctrl_resolve_in,
  output logic [NREAD*DBITS-1:0]     regval_out,
  output logic                       stall_out,
  output logic                       issue_fire_out,
  output logic [REGWORDS-1:0]        busy_vec_out,
  output logic                       err_out
);
  typedef enum logic {S_IDLE = 1'b0, S_SHADOW = 1'b1} state_t;

  logic [DBITS-1:0]                    r_regs [REGWORDS];
  logic [REGWORDS-1:0][PEND_BITS-1:0]  w_pend;
  logic [REGWORDS-1:0]                 w_uflow;
  logic [NREAD-1:0]                    w_raw;
  logic                                w_sat;
  logic                                w_fire;
  logic                                r_err;
  state_t                              r_state, w_state_nxt;
  logic [3:0]                          r_sh_cnt, w_sh_nxt;

  // ---------------- register file ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < REGWORDS; r++) r_regs[r] <= '0;
    end else if (wb_valid_in && wb_regno_in != '0) begin
      r_regs[wb_regno_in] <= wb_val_in;
    end
  end

  // ---------------- read ports and RAW detection ----------------
  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
    logic [REGNOBITS-1:0] w_rs;
    logic [PEND_BITS-1:0] w_p;
    logic                 w_wbhit;

    assign w_rs    = rs_in[gi*REGNOBITS +: REGNOBITS];
    assign w_p     = w_pend[w_rs];
    assign w_wbhit = (BYPASS_WB != 0) && wb_valid_in && (wb_regno_in == w_rs);

    assign regval_out[gi*DBITS +: DBITS] =
      (w_rs == '0) ? '0 : (w_wbhit ? wb_val_in : r_regs[w_rs]);

    // the last outstanding write landing this cycle is forwarded, so no stall
    assign w_raw[gi] = rs_read_in[gi] && (w_rs != '0) && (w_p != '0) &&
                       !(w_wbhit && w_p == PEND_BITS'(1));
  end

  assign w_sat          = wr_reg_in && (w_pend[rd_in] == '1);
  assign stall_out      = issue_valid_in && ((|w_raw) || w_sat || r_state == S_SHADOW);
  assign w_fire         = issue_valid_in && !stall_out;
  assign issue_fire_out = w_fire;

  // ---------------- pending counters ----------------
  for (genvar gr = 0; gr < REGWORDS; gr++) begin : g_pend
    if (gr == 0) begin : g_r0
      assign w_pend[gr]  = '0;
      assign w_uflow[gr] = 1'b0;
    end else begin : g_rn
      logic w_inc, w_dec;
      assign w_inc = w_fire && wr_reg_in && (rd_in == REGNOBITS'(gr));
      assign w_dec = wb_valid_in && (wb_regno_in == REGNOBITS'(gr));
      de_sb_pend_cnt #(.PEND_BITS(PEND_BITS)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_inc),
        .i_dec   (w_dec),
        .o_cnt   (w_pend[gr]),
        .o_uflow (w_uflow[gr])
      );
    end
    assign busy_vec_out[gr] = |w_pend[gr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_err <= 1'b0;
    else        r_err <= r_err | (|w_uflow);
  end
  assign err_out = r_err;

  // ---------------- control shadow FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_sh_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sh_cnt <= w_sh_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_fire && is_ctrl_in) begin
          w_state_nxt = S_SHADOW;
          w_sh_nxt    = 4'(BR_SHADOW);
        end
      end
      S_SHADOW: begin
        if (ctrl_resolve_in || r_sh_cnt == 4'd1) begin
          w_state_nxt = S_IDLE;
          w_sh_nxt    = '0;
        end else begin
          w_sh_nxt    = r_sh_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_sh_nxt    = '0;
      end
    endcase
  end
endmodule
